// File: rtl/if_stage_fq.sv
// Instruction fetch stage with a decoupled fetch queue.
// Requests go out to the instruction SRAM whenever credits allow. Each
// accepted PC waits in an in-order outstanding FIFO until its data returns.
// Returned words are paired with that PC and buffered for decode.
// On a taken branch the queue is flushed. Responses still in flight are
// counted off and dropped when they arrive.
module if_stage_fq #(
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FQ_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic        w_br_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;

  logic [31:0]   r_pc;
  logic [31:0]   r_of_pc [FQ_DEPTH];
  logic [AW-1:0] r_of_wp;
  logic [AW-1:0] r_of_rp;
  logic [CW-1:0] r_of_cnt;
  logic [63:0]   r_fq_data [FQ_DEPTH];
  logic [AW-1:0] r_fq_wp;
  logic [AW-1:0] r_fq_rp;
  logic [CW-1:0] r_fq_cnt;
  logic [CW-1:0] r_cancel;

  logic          w_acc;
  logic          w_rsp;
  logic          w_fq_push;
  logic          w_fq_pop;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_of_cnt_nxt;

  assign {w_br_stall, w_br_taken, w_br_target} = br_bus;

  // Outstanding requests plus buffered entries never exceed the queue depth,
  // so every response that is accepted has a slot waiting for it.
  assign w_inflight    = {1'b0, r_of_cnt} + {1'b0, r_fq_cnt};
  assign inst_sram_req = resetn && !w_br_stall && (w_inflight < DEPTH_C);
  assign inst_sram_addr  = r_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign w_acc     = inst_sram_req && inst_sram_addr_ok;
  // A data_ok with nothing outstanding is a slave protocol error. It is ignored.
  assign w_rsp     = inst_sram_data_ok && (r_of_cnt != '0);
  assign w_fq_push = w_rsp && (r_cancel == '0) && !w_br_taken;

  assign fs_to_ds_valid = resetn && (r_fq_cnt != '0) && !w_br_taken;
  assign fs_to_ds_bus   = r_fq_data[r_fq_rp];
  assign w_fq_pop       = fs_to_ds_valid && ds_allowin;

  assign w_of_cnt_nxt = r_of_cnt + {{AW{1'b0}}, w_acc} - {{AW{1'b0}}, w_rsp};

  // PC, pointers, occupancy and cancel bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc     <= RESET_PC;
      r_of_wp  <= '0;
      r_of_rp  <= '0;
      r_of_cnt <= '0;
      r_fq_wp  <= '0;
      r_fq_rp  <= '0;
      r_fq_cnt <= '0;
      r_cancel <= '0;
    end else begin
      if (w_br_taken)
        r_pc <= w_br_target;
      else if (w_acc)
        r_pc <= r_pc + 32'd4;

      if (w_acc) r_of_wp <= r_of_wp + PTR_ONE;
      if (w_rsp) r_of_rp <= r_of_rp + PTR_ONE;
      r_of_cnt <= w_of_cnt_nxt;

      if (w_br_taken) begin
        // Everything still in flight after this edge belongs to the old path.
        // That includes a request accepted in this same cycle.
        r_fq_wp  <= '0;
        r_fq_rp  <= '0;
        r_fq_cnt <= '0;
        r_cancel <= w_of_cnt_nxt;
      end else begin
        if (w_fq_push) r_fq_wp <= r_fq_wp + PTR_ONE;
        if (w_fq_pop)  r_fq_rp <= r_fq_rp + PTR_ONE;
        r_fq_cnt <= r_fq_cnt + {{AW{1'b0}}, w_fq_push} - {{AW{1'b0}}, w_fq_pop};
        if (w_rsp && (r_cancel != '0))
          r_cancel <= r_cancel - CNT_ONE;
      end
    end
  end

  // Storage arrays for outstanding PCs and fetched instructions
  always_ff @(posedge clk) begin
    if (w_acc)
      r_of_pc[r_of_wp] <= r_pc;
    if (resetn && w_fq_push)
      r_fq_data[r_fq_wp] <= {inst_sram_rdata, r_of_pc[r_of_rp]};
  end

endmodule

// File: tb/tb_if_stage_fq.sv
// Testbench for if_stage_fq.
// The bench keeps a queue-based model of the fetch stage and plays the role
// of the instruction SRAM slave. A free-running compare process checks the
// DUT against the model every cycle. Directed scenarios add fixed literal
// expectations, and a long randomized phase follows them.
module tb_if_stage_fq;

  localparam int unsigned FQ     = 4;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  if_stage_fq #(.FQ_DEPTH(FQ), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            ({br_stall, br_taken, br_target}),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state, updated once per cycle by the compare process
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_out[$];
  logic [63:0] m_fq[$];
  int unsigned m_cancel = 0;
  bit          armed = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model
  initial begin
    logic e_req, e_val, acc, rsp;
    logic [31:0] p;
    forever begin
      @(negedge clk);
      #1;
      e_req = resetn && !br_stall && ((m_out.size() + m_fq.size()) < FQ);
      e_val = resetn && (m_fq.size() > 0) && !br_taken;
      if (armed) begin
        chk("req", {63'd0, inst_sram_req}, {63'd0, e_req});
        chk("addr", {32'd0, inst_sram_addr}, {32'd0, m_pc});
        chk("valid", {63'd0, fs_to_ds_valid}, {63'd0, e_val});
        if (e_val) chk("bus", fs_to_ds_bus, m_fq[0]);
        chk("tieoffs", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
            {25'd0, 1'b0, 2'd2, 4'h0, 32'h0});
      end
      if (!resetn) begin
        m_pc = RST_PC;
        m_out.delete();
        m_fq.delete();
        m_cancel = 0;
        armed = 1;
      end else begin
        acc = e_req && addr_ok;
        rsp = data_ok && (m_out.size() > 0);
        if (e_val && ds_allowin) void'(m_fq.pop_front());
        if (rsp) begin
          p = m_out.pop_front();
          if (!br_taken) begin
            if (m_cancel > 0) m_cancel--;
            else m_fq.push_back({rdata, p});
          end
        end
        if (acc) begin
          m_out.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (br_taken) begin
          m_pc = br_target;
          m_fq.delete();
          m_cancel = m_out.size();
        end
      end
    end
  end

  task automatic cyc(input logic rn, input logic ds, input logic st, input logic tk,
                     input logic [31:0] tg, input logic aok, input logic dok);
    @(negedge clk);
    resetn     = rn;
    ds_allowin = ds;
    br_stall   = st;
    br_taken   = tk;
    br_target  = tg;
    addr_ok    = aok;
    data_ok    = dok;
    rdata      = (m_out.size() > 0) ? inst_of(m_out[0]) : $urandom;
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'($urandom % 2));
  endtask

  initial begin
    int n;
    bit found;
    logic [31:0] a0;
    resetn = 1'b0; ds_allowin = 1'b0; br_stall = 1'b0; br_taken = 1'b0;
    br_target = '0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;

    // Reset holds req and valid low
    rst(3);
    #2;
    chk("rst_req", {63'd0, inst_sram_req}, 64'd0);
    chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);

    // Streaming with an always-ready slave
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #2;
      if (i == 0) begin
        chk("stream_addr0", {32'd0, inst_sram_addr}, 64'h1c000000);
        chk("stream_req0", {63'd0, inst_sram_req}, 64'd1);
      end
      if (i >= 2) begin
        chk("stream_valid", {63'd0, fs_to_ds_valid}, 64'd1);
        chk("stream_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, 32'h1c000000 + 32'(4 * (i - 2))});
      end
    end

    // Decode blocked: the queue fills to depth, then drains in order
    rst(1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #2;
      if (inst_sram_req) n++;
    end
    chk("full_accepts", 64'(n), 64'd4);
    chk("full_req_low", {63'd0, inst_sram_req}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk("drain_valid", {63'd0, fs_to_ds_valid}, 64'd1);
      chk("drain_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, 32'h1c000000 + 32'(4 * i)});
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("drain_req_resume", {63'd0, inst_sram_req}, 64'd1);

    // Branch with three requests in flight
    rst(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h1c000100, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #2;
      if (fs_to_ds_valid) begin
        found = 1;
        chk("br_first_pc", {32'd0, fs_to_ds_bus[31:0]}, 64'h1c000100);
      end
    end
    chk("br_delivered", {63'd0, found}, 64'd1);

    // Branch coinciding with addr_ok and data_ok
    rst(1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h1c000200, 1'b1, 1'b1);
    #2;
    chk("coin_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #2;
      chk("coin_after_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    end

    // Stall: no requests, PC frozen, queue still drains
    rst(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n = 0;
    a0 = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      #2;
      if (i == 0) a0 = inst_sram_addr;
      chk("stall_req", {63'd0, inst_sram_req}, 64'd0);
      chk("stall_addr", {32'd0, inst_sram_addr}, 64'h1c00000c);
      if (fs_to_ds_valid) n++;
    end
    chk("stall_addr_hold", {32'd0, a0}, 64'h1c00000c);
    chk("stall_delivered", 64'(n), 64'd3);

    // Reset with two requests in flight; stale data_ok afterwards
    rst(1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #2;
      chk("rel_addr", {32'd0, inst_sram_addr}, {32'd0, RST_PC});
      chk("rel_req", {63'd0, inst_sram_req}, 64'd1);
      chk("rel_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic dok;
      dok = (m_out.size() > 0) ? 1'($urandom % 2) : 1'(($urandom % 32) == 0);
      cyc(1'(($urandom % 100) != 0), 1'(($urandom % 10) < 7), 1'(($urandom % 10) == 0),
          1'(($urandom % 20) == 0), $urandom & 32'hfffffffc, 1'(($urandom % 10) < 6), dok);
    end
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
